// File: rtl/my_ram_be.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | my_ram_be : simple dual-port RAM with byte enables, 1/2-cycle read       |
// |             latency with read-valid strobe, and a clear sweep on reset.  |
// | Option    : MY_RAM_BE_WR_FWD_EN selects write-first collision reads.     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module my_ram_be #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_done,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int c_nb    = DATA_WIDTH / 8;
  localparam int c_depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH:0]     r_cnt;
  logic [ADDR_WIDTH:0]     w_cnt_next;
  logic [DATA_WIDTH-1:0]   r_mem [c_depth];
  logic                    w_sweep_we;
  logic                    w_wr_user;
  logic                    w_rd_issue;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [DATA_WIDTH-1:0]   r_d1;
  logic                    r_v1;

  assign w_cnt_next = r_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_sweep_we = (r_state == CLEAR) && rst_n;
  assign w_wr_user  = wr_en && (r_state == READY);
  assign w_rd_issue = rd_en && (r_state == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The extra counter bit flags completion once the last address is written.
  always_comb begin
    w_state_next = r_state;
    init_done    = 1'b0;
    case (r_state)
      CLEAR: begin
        if (w_cnt_next[ADDR_WIDTH]) begin
          w_state_next = READY;
        end
      end
      READY: begin
        init_done = 1'b1;
      end
      default: begin
        w_state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[r_cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    end else if (w_wr_user) begin
      for (int i = 0; i < c_nb; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef MY_RAM_BE_WR_FWD_EN
  // Write-first: enabled bytes of a same-address write replace the old word.
  always_comb begin
    w_rd_word = r_mem[rd_addr];
    if (w_wr_user && (wr_addr == rd_addr)) begin
      for (int i = 0; i < c_nb; i++) begin
        if (wr_be[i]) begin
          w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end
`else
  assign w_rd_word = r_mem[rd_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_rd_issue;
      if (w_rd_issue) begin
        r_d1 <= w_rd_word;
      end
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign rd_data  = r_d1;
      assign rd_valid = r_v1;
    end else if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_d2;
      logic                  r_v2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= r_d1;
          end
        end
      end
      assign rd_data  = r_d2;
      assign rd_valid = r_v2;
    end else begin : g_lat_bad
      $error("my_ram_be: RD_LATENCY must be 1 or 2");
      assign rd_data  = '0;
      assign rd_valid = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/my_ram_be.md
Name: my_ram_be

Overview:
- Next-generation simple dual-port RAM for the UART/CPU data paths.
- Single clock, one write port and one read port.
- Adds per-byte write enables, selectable read latency (1 or 2) with a read-valid strobe, and a hardware clear sweep after reset.
- Sits behind UART RX/TX buffers and CPU scratch storage wherever a cleared, byte-writable buffer is needed.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2; any other value is an elaboration error.
- INIT_VALUE, 0, word value written to every location by the clear sweep.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- init_done  output  1  high once the clear sweep completes; low during reset and sweep.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  NB  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  one-cycle strobe: rd_data carries a new read result.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to CLEAR; sweep counter = 0.
  - init_done=0, rd_valid=0, rd_data=0; all read pipeline valid bits cleared.
  - The memory array itself has no reset.
- FSM states are CLEAR and READY.
- CLEAR:
  - Each cycle after rst_n rises, writes INIT_VALUE to address = counter, then increments the counter.
  - After writing address 2**ADDR_WIDTH-1, goes to READY; the sweep takes exactly 2**ADDR_WIDTH cycles.
  - wr_en and rd_en are ignored: no user write, and no read is issued, so rd_valid stays 0.
- READY: init_done=1 from the first READY cycle; the FSM stays in READY until reset.
- Reset asserted mid-sweep or mid-read: sweep restarts from address 0; in-flight reads are discarded with no rd_valid.
- Write (READY, wr_en=1):
  - At the clock edge, byte lane i of ram[wr_addr] takes wr_data lane i only where wr_be[i]=1; other lanes are unchanged.
  - wr_be=0 is a no-op.
- Read (READY, rd_en=1 at edge N):
  - RD_LATENCY=1: rd_data = ram[rd_addr] and rd_valid=1 after edge N+1.
  - RD_LATENCY=2: a second output register is added; the result appears after edge N+2.
  - Back-to-back reads every cycle give one result per cycle, in order.
- rd_data holds its last value when no read completes; rd_valid=0 in those cycles.
- Same-address read and write in the same cycle: governed by the optional feature below.
- Different-address read and write in the same cycle: independent, with no interaction.
- Address wrap: none; every address is in range; the sweep counter has ADDR_WIDTH+1 bits so termination is detected without wrapping.

Optional Feature:
- Macro: MY_RAM_BE_WR_FWD_EN.
- Defined: on a same-address collision, the read returns the merged word: wr_data bytes where wr_be=1, old ram bytes elsewhere (write-first).
- Not defined: on a collision, the read returns the full old word (read-first); no bypass logic is built.
- Latency and rd_valid timing are identical in both builds.

Test Plan:
- Reset, then wait:
  - init_done rises after exactly 2**ADDR_WIDTH cycles (256 at default).
  - Read of addresses 0, 0x7F and 0xFF returns INIT_VALUE (0).
  - rd_en pulsed during the sweep produces no rd_valid.
- Byte enables: write 0x11223344 to addr 5 with be=4'hF, then write 0xAABBCCDD with be=4'b0101 -> read of addr 5 returns 0x11BB33DD.
- Latency: with RD_LATENCY=1 and 2, issue reads on 4 consecutive cycles to addrs 1..4 preloaded with 0xA1..0xA4:
  - rd_valid appears 1 or 2 cycles later for 4 consecutive cycles.
  - Data arrives in order 0xA1..0xA4.
- Collision: addr 9 holds 0x0; same-cycle write 0xFFFFFFFF be=4'b0011 and read of addr 9:
  - Macro undefined -> 0x00000000.
  - Macro defined -> 0x0000FFFF.
- Reset mid-operation:
  - Assert rst_n=0 at sweep cycle 100 -> init_done stays 0, and the sweep restarts and completes 256 cycles after release.
  - Assert rst_n=0 with a read in flight at RD_LATENCY=2 -> rd_valid=0 and rd_data=0 immediately.
- Idle hold: after a read returns 0x12345678, 10 idle cycles -> rd_data stays 0x12345678 and rd_valid stays 0.
